// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : decoupled instruction fetch with a credit-limited {PC, Instr}
//               FIFO; redirects flush the queue and drop in-flight responses.
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w:0]   c_depth_wide = (c_cnt_w + 1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(DEPTH);

  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [31:0]          resp_pc_q, resp_pc_d;
  logic [c_ptr_w-1:0]   head_q, head_d;
  logic [c_ptr_w-1:0]   tail_q, tail_d;
  logic [c_cnt_w-1:0]   count_q, count_d;
  logic [c_cnt_w-1:0]   outstanding_q, outstanding_d;
  logic [c_cnt_w-1:0]   discard_q, discard_d;
  logic [31:0]          instr_mem_q [DEPTH];
  logic [31:0]          instr_mem_d [DEPTH];
  logic [31:0]          pc_mem_q [DEPTH];
  logic [31:0]          pc_mem_d [DEPTH];

  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic [c_cnt_w:0]     w_credit_used;
  logic [c_cnt_w-1:0]   w_outstanding_nxt;
  logic [31:0]          w_redirect_tgt;

  // Queued words plus in-flight requests never exceed DEPTH, so a push always has room.
  assign w_credit_used     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign w_issue           = !reset && !redirect && (w_credit_used < c_depth_wide);
  assign w_outstanding_nxt = outstanding_q + c_cnt_w'(w_issue) - c_cnt_w'(imem_ack);
  assign w_push            = imem_ack && (discard_q == '0) && !redirect;
  assign w_pop             = instr_valid && instr_ready && !redirect;
  assign w_redirect_tgt    = {redirect_pc[31:2], 2'b00};

  assign imem_req    = w_issue;
  assign imem_addr   = reset ? RESET_PC : fetch_pc_q;
  assign instr_valid = !reset && (count_q != '0);
  assign Instr       = reset ? 32'h0 : instr_mem_q[head_q];
  assign PC          = reset ? 32'h0 : pc_mem_q[head_q];
  assign PCPlus8     = PC + 32'd8;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    outstanding_d = w_outstanding_nxt;
    discard_d     = discard_q;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;

    if (redirect) begin
      // Everything still in flight, including a word acked this cycle, is stale.
      fetch_pc_d = w_redirect_tgt;
      resp_pc_d  = w_redirect_tgt;
      tail_d     = head_q;
      count_d    = '0;
      discard_d  = w_outstanding_nxt;
    end else begin
      if (w_issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_ack && (discard_q != '0)) begin
        discard_d = discard_q - c_cnt_w'(1);
      end
      if (w_push) begin
        instr_mem_d[tail_q] = imem_rdata;
        pc_mem_d[tail_q]    = resp_pc_q;
        resp_pc_d           = resp_pc_q + 32'd4;
        tail_d              = tail_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        head_d = head_q + c_ptr_w'(1);
      end
      count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0;
        pc_mem_q[i]    <= 32'h0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      instr_mem_q   <= instr_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (count_q == c_depth)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed self-checking bench for fetch_queue.
// Revision       : 1.0
// ============================================================================
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hDEAD_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus8;

  int n_vec = 0;
  int n_err = 0;
  int mem_lat = 1;
  int mem_cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instr(Instr), .PC(PC), .PCPlus8(PCPlus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fixed-latency in-order memory; each word is its address XOR KEY.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk); #1;
      mem_cyc++;
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
      end else begin
        if (mq_due.size() > 0 && mq_due[0] <= mem_cyc) begin
          imem_ack   = 1'b1;
          imem_rdata = mq_addr[0] ^ KEY;
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'h0;
        end
        if (imem_req) begin
          mq_addr.push_back(imem_addr);
          mq_due.push_back(mem_cyc + mem_lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Leaves the bench one step after the rising edge of cycle 0 after release.
  task automatic do_reset(input int lat, input logic rdy);
    @(posedge clk); #1;
    reset = 1'b1; redirect = 1'b0; instr_ready = rdy; mem_lat = lat;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; redirect = 1'b0; instr_ready = 1'b0; mem_lat = 1;
    @(negedge clk);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL rst_addr got %h exp %h", imem_addr, RESET_PC); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    n_vec++; if (Instr !== 32'h0 || PC !== 32'h0) begin n_err++; $display("FAIL rst_head got instr %h pc %h exp 0 0", Instr, PC); end
    n_vec++; if (PCPlus8 !== 32'd8) begin n_err++; $display("FAIL rst_pcplus8 got %h exp 8", PCPlus8); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL first_req got %b/%h exp 1/%h", imem_req, imem_addr, RESET_PC); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL first_valid got %b exp 0", instr_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL stream_req c%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, 32'(4 * k)); end
      n_vec++; if (instr_valid !== (k >= 2)) begin n_err++; $display("FAIL stream_valid c%0d got %b exp %b", k, instr_valid, (k >= 2)); end
      if (k >= 2) begin
        exp_pc = 32'(4 * (k - 2));
        n_vec++; if (PC !== exp_pc || Instr !== (exp_pc ^ KEY) || PCPlus8 !== exp_pc + 32'd8) begin
          n_err++; $display("FAIL stream_head c%0d got pc %h instr %h p8 %h exp %h %h %h", k, PC, Instr, PCPlus8, exp_pc, exp_pc ^ KEY, exp_pc + 32'd8);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    logic [31:0] exp_pc;
    do_reset(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_req === 1'b1) nreq++;
      step();
    end
    // Bench is now in cycle 10; cycle-9 state is still held since nothing moved.
    @(negedge clk);
    n_vec++; if (nreq != 4) begin n_err++; $display("FAIL stall_reqs got %0d exp 4", nreq); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req_low got %b exp 0", imem_req); end
    n_vec++; if (dut.count_q !== 3'd4) begin n_err++; $display("FAIL stall_count got %0d exp 4", dut.count_q); end
    n_vec++; if (instr_valid !== 1'b1 || PC !== 32'h0) begin n_err++; $display("FAIL stall_head got %b/%h exp 1/0", instr_valid, PC); end
    step();
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_pc = 32'(4 * k);
      n_vec++; if (instr_valid !== 1'b1 || PC !== exp_pc || Instr !== (exp_pc ^ KEY)) begin
        n_err++; $display("FAIL drain_head k%0d got %b/%h/%h exp 1/%h/%h", k, instr_valid, PC, Instr, exp_pc, exp_pc ^ KEY);
      end
      if (k == 0) begin
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL drain_req0 got %b exp 0", imem_req); end
      end
      if (k == 1) begin
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL resume_req got %b/%h exp 1/00000010", imem_req, imem_addr); end
      end
      step();
    end
  endtask

  task automatic test_redirect_stale();
    logic [31:0] exp_pc;
    do_reset(3, 1'b1);
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    n_vec++; if (dut.outstanding_q !== 3'd3) begin n_err++; $display("FAIL stale_inflight got %0d exp 3", dut.outstanding_q); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stale_req_blocked got %b exp 0", imem_req); end
    step();
    redirect = 1'b0;
    @(negedge clk);
    n_vec++; if (dut.discard_q !== 3'd2) begin n_err++; $display("FAIL stale_discard got %0d exp 2", dut.discard_q); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stale_valid_n1 got %b exp 0", instr_valid); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL stale_target_req got %b/%h exp 1/00000100", imem_req, imem_addr); end
    step();
    for (int c = 5; c <= 10; c++) begin
      @(negedge clk);
      n_vec++; if (instr_valid !== (c >= 8)) begin n_err++; $display("FAIL stale_valid c%0d got %b exp %b", c, instr_valid, (c >= 8)); end
      if (c >= 8) begin
        exp_pc = 32'h100 + 32'(4 * (c - 8));
        n_vec++; if (PC !== exp_pc || Instr !== (exp_pc ^ KEY)) begin n_err++; $display("FAIL stale_head c%0d got %h/%h exp %h/%h", c, PC, Instr, exp_pc, exp_pc ^ KEY); end
      end
      step();
    end
  endtask

  task automatic test_redirect_ack_pop();
    logic [31:0] exp_pc;
    do_reset(2, 1'b1);
    step(); step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    n_vec++; if (instr_valid !== 1'b1 || PC !== 32'h4 || imem_ack !== 1'b1) begin
      n_err++; $display("FAIL rap_setup got v%b pc %h ack %b exp v1 pc 00000004 ack 1", instr_valid, PC, imem_ack);
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    n_vec++; if (dut.count_q !== 3'd0) begin n_err++; $display("FAIL rap_count got %0d exp 0", dut.count_q); end
    n_vec++; if (dut.discard_q !== 3'd1) begin n_err++; $display("FAIL rap_discard got %0d exp 1", dut.discard_q); end
    n_vec++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin n_err++; $display("FAIL rap_n1 got v%b addr %h exp v0 addr 00000200", instr_valid, imem_addr); end
    step();
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      n_vec++; if (instr_valid !== (c >= 8)) begin n_err++; $display("FAIL rap_valid c%0d got %b exp %b", c, instr_valid, (c >= 8)); end
      if (c >= 8) begin
        exp_pc = 32'h200 + 32'(4 * (c - 8));
        n_vec++; if (PC !== exp_pc) begin n_err++; $display("FAIL rap_head c%0d got %h exp %h", c, PC, exp_pc); end
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [5];
    logic [31:0] exp_pc [5];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
    exp_addr[3] = 32'h0000_0004; exp_addr[4] = 32'h0000_0008;
    exp_pc[0]   = 32'h0;         exp_pc[1]   = 32'h0;         exp_pc[2]   = 32'hFFFF_FFF8;
    exp_pc[3]   = 32'hFFFF_FFFC; exp_pc[4]   = 32'h0000_0000;
    do_reset(1, 1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++; if (imem_addr !== exp_addr[k]) begin n_err++; $display("FAIL wrap_addr k%0d got %h exp %h", k, imem_addr, exp_addr[k]); end
      if (k >= 2) begin
        n_vec++; if (instr_valid !== 1'b1 || PC !== exp_pc[k] || PCPlus8 !== exp_pc[k] + 32'd8) begin
          n_err++; $display("FAIL wrap_head k%0d got v%b pc %h p8 %h exp v1 pc %h p8 %h", k, instr_valid, PC, PCPlus8, exp_pc[k], exp_pc[k] + 32'd8);
        end
      end
      step();
    end
  endtask

  task automatic test_midstream_reset();
    do_reset(1, 1'b0);
    step(); step(); step(); step();
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (dut.count_q !== 3'd3) begin n_err++; $display("FAIL mid_precount got %0d exp 3", dut.count_q); end
    n_vec++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL mid_during got v%b req %b addr %h exp v0 req 0 addr %h", instr_valid, imem_req, imem_addr, RESET_PC);
    end
    n_vec++; if (PCPlus8 !== 32'd8 || Instr !== 32'h0) begin n_err++; $display("FAIL mid_during_head got p8 %h instr %h exp 8 0", PCPlus8, Instr); end
    step();
    reset = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_vec++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC || PCPlus8 !== 32'd8) begin
          n_err++; $display("FAIL mid_after got v%b req %b addr %h p8 %h exp v0 req 1 addr %h p8 8", instr_valid, imem_req, imem_addr, PCPlus8, RESET_PC);
        end
      end
      n_vec++; if (instr_valid !== (k >= 2)) begin n_err++; $display("FAIL mid_valid k%0d got %b exp %b", k, instr_valid, (k >= 2)); end
      if (k >= 2) begin
        n_vec++; if (PC !== 32'(4 * (k - 2))) begin n_err++; $display("FAIL mid_head k%0d got %h exp %h", k, PC, 32'(4 * (k - 2))); end
      end
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_ack_pop();
    test_wrap();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly upstream of the datapath, replacing the bare PC register with a decoupled front end. It issues word-aligned instruction-memory reads ahead of execution, buffers the returned words with their PCs in a small FIFO, and presents the head entry's Instr, PC and PCPlus8 to decode/datapath over a valid/ready handshake. A branch redirect, the taken-PCSrc path, flushes the queue, discards in-flight responses and restarts fetch at the target.

## Interface
- DEPTH, 4: queue entries and maximum in-flight credit; power of two, ≥2.
- RESET_PC, 32'h00000000: first fetch address after reset; word aligned.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle; memory accepts every request, no back-pressure.
- imem_addr  out  32  request address (fetch_pc).
- imem_ack  in  1  one response per request, in order, ≥1 cycle after its request.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- redirect  in  1  branch taken; flush and refetch.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0).
- instr_valid  out  1  head entry valid.
- instr_ready  in  1  consumer pops head when instr_valid & instr_ready.
- Instr  out  32  head instruction.
- PC  out  32  head instruction address.
- PCPlus8  out  32  PC + 8, combinational, mod 2^32.

## Operation
- State: fetch_pc, resp_pc (address of next expected response), FIFO head/tail pointers with count (0..DEPTH), outstanding (0..DEPTH), discard (0..DEPTH).
- Issue: imem_req = !reset & !redirect & (count + outstanding < DEPTH). On issue, fetch_pc += 4.
- outstanding_next = outstanding + issue - imem_ack.
- Response with discard > 0: word dropped, discard -= 1, resp_pc unchanged.
- Response with discard == 0: push {resp_pc, imem_rdata}, resp_pc += 4.
- Pop: instr_valid & instr_ready & !redirect advances head.
- Simultaneous push and pop: count unchanged, both performed.
- Credit rule guarantees no overflow; a push when count == DEPTH is a design error and is flagged by an assertion.
- Redirect cycle:
  - count cleared; pop and push in that cycle are ignored.
  - fetch_pc and resp_pc take {redirect_pc[31:2], 2'b00}.
  - discard takes outstanding_next, so every word still in flight is stale, including any acked that cycle.
- Requests issued after a redirect may overlap stale responses; in-order return makes the first `discard` acks the stale ones.
- Redirect asserted while discard > 0: discard takes the new outstanding_next; it never accumulates beyond outstanding.
- Address arithmetic wraps: 32'hFFFFFFFC + 4 = 32'h00000000.

## Timing
- Reset, synchronous, any cycle including mid-stream:
  - fetch_pc = resp_pc = RESET_PC; count = outstanding = discard = 0; all FIFO slots cleared to 0.
  - Outputs during and after the reset cycle: imem_req 0, imem_addr RESET_PC, instr_valid 0, Instr 0, PC 0, PCPlus8 8.
  - Responses arriving after reset for pre-reset requests are outside the protocol; the memory is reset together with this block.
- First request: cycle 0 after reset release (imem_req 1, imem_addr RESET_PC).
- Ack-to-valid latency is one cycle: the FIFO is registered, so a word acked in cycle N is visible in cycle N+1.
- With 1-cycle memory latency, first instr_valid is cycle 2; sustained throughput is 1 instruction per cycle while instr_ready is held high.
- Redirect in cycle N:
  - instr_valid 0 in N+1.
  - Target requested in N+1.
  - Target instruction valid no earlier than N+3 with 1-cycle memory.
- Head outputs hold stable while instr_valid & !instr_ready. When the queue is empty, outputs hold the last head slot contents; the consumer must ignore them.

## Test plan
- Reset release, memory latency 1, instr_ready held 1 → requests at 0x0, 0x4, 0x8, …; instr_valid from cycle 2; PC 0x0, 0x4, 0x8 on consecutive cycles; PCPlus8 = PC+8.
- instr_ready 0 for 10 cycles → exactly DEPTH=4 requests issued, count 4, imem_req 0. instr_ready 1 → 4 pops, then fetch resumes without gap or duplicate.
- Memory latency 3 with 3 requests in flight; redirect to 0x100 → the 3 stale words are dropped; first valid PC is 0x100 and the next is 0x104.
- Redirect in the same cycle as an ack and a pop → ack discarded; count 0 next cycle; discard equals in-flight count; no entry is presented twice.
- redirect_pc 32'hFFFFFFF8 → PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; PCPlus8 for 0xFFFFFFFC is 0x00000004.
- Reset asserted mid-stream with count 3 → next cycle instr_valid 0, imem_addr RESET_PC, PCPlus8 8; stream restarts from RESET_PC.
